// File: rtl/stage_timer_sequencer.sv
// Runs up to STAGES timed phases back-to-back from one shared elapsed counter.
// Each enabled stage lasts (limit + 1) unpaused cycles; disabled stages are skipped at zero cost.
module stage_timer_sequencer #(
  parameter int COUNTER_BITS = 32,
  parameter int STAGES       = 4,
  parameter int STAGE_BITS   = 2
) (
  input  logic                           i_CLK,
  input  logic                           i_RST_N,
  input  logic                           i_START,
  input  logic                           i_PAUSE,
  input  logic                           i_ABORT,
  input  logic [STAGES-1:0]              i_STAGE_EN,
  input  logic [STAGES*COUNTER_BITS-1:0] i_LIM_FLAT,
  output logic                           o_BUSY,
  output logic [STAGE_BITS-1:0]          o_STAGE,
  output logic [COUNTER_BITS-1:0]        o_ELAPSED,
  output logic                           o_STAGE_DONE,
  output logic [STAGE_BITS-1:0]          o_DONE_STAGE,
  output logic                           o_ALL_DONE
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiet
  // RUN   | timing the stage in o_STAGE
  // DONE  | every enabled stage finished, o_ALL_DONE high
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [STAGES-1:0]       en_q;
  logic [COUNTER_BITS-1:0] lim_q [STAGES];

  logic                    first_found;
  logic [STAGE_BITS-1:0]   first_idx;
  logic                    next_found;
  logic [STAGE_BITS-1:0]   next_idx;
  logic [COUNTER_BITS-1:0] cur_lim;

  // Lowest enabled stage from the live inputs (used at start) and the next
  // enabled stage above the current one from the latched copy (used in RUN).
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (i_STAGE_EN[k]) begin
        first_found = 1'b1;
        first_idx   = STAGE_BITS'(k);
      end
      if (en_q[k] && (k > int'(o_STAGE))) begin
        next_found = 1'b1;
        next_idx   = STAGE_BITS'(k);
      end
    end
  end

  assign cur_lim = lim_q[o_STAGE];

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state        <= IDLE;
      en_q         <= '0;
      for (int k = 0; k < STAGES; k++) lim_q[k] <= '0;
      o_BUSY       <= 1'b0;
      o_STAGE      <= '0;
      o_ELAPSED    <= '0;
      o_STAGE_DONE <= 1'b0;
      o_DONE_STAGE <= '0;
      o_ALL_DONE   <= 1'b0;
    end else begin
      o_STAGE_DONE <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (i_ABORT) begin
            state      <= IDLE;
            o_ALL_DONE <= 1'b0;
          end else if (i_START) begin
            en_q <= i_STAGE_EN;
            for (int k = 0; k < STAGES; k++)
              lim_q[k] <= i_LIM_FLAT[k*COUNTER_BITS +: COUNTER_BITS];
            o_ELAPSED <= '0;
            if (first_found) begin
              state      <= RUN;
              o_STAGE    <= first_idx;
              o_BUSY     <= 1'b1;
              o_ALL_DONE <= 1'b0;
            end else begin
              state      <= DONE;
              o_STAGE    <= '0;
              o_BUSY     <= 1'b0;
              o_ALL_DONE <= 1'b1;
            end
          end
        end
        RUN: begin
          if (i_ABORT) begin
            state     <= IDLE;
            o_BUSY    <= 1'b0;
            o_ELAPSED <= '0;
            o_STAGE   <= '0;
          end else if (!i_PAUSE) begin
            if (o_ELAPSED == cur_lim) begin
              o_STAGE_DONE <= 1'b1;
              o_DONE_STAGE <= o_STAGE;
              o_ELAPSED    <= '0;
              if (next_found) begin
                o_STAGE <= next_idx;
              end else begin
                state      <= DONE;
                o_BUSY     <= 1'b0;
                o_ALL_DONE <= 1'b1;
              end
            end else begin
              o_ELAPSED <= o_ELAPSED + COUNTER_BITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_timer_sequencer.sv
// Scoreboard bench: directed runs push expected completion/done events with their cycle;
// a negedge monitor pops and compares whenever the DUT pulses o_STAGE_DONE or raises o_ALL_DONE.
module tb_stage_timer_sequencer;
  localparam int CB = 32;
  localparam int NS = 4;
  localparam int SB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [NS-1:0] stage_en = '0;
  logic [NS*CB-1:0] lim_flat = '0;
  logic          busy;
  logic [SB-1:0] stage;
  logic [CB-1:0] elapsed;
  logic          stage_done;
  logic [SB-1:0] done_stage;
  logic          all_done;

  stage_timer_sequencer #(.COUNTER_BITS(CB), .STAGES(NS), .STAGE_BITS(SB)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_START(start), .i_PAUSE(pause), .i_ABORT(abort),
    .i_STAGE_EN(stage_en), .i_LIM_FLAT(lim_flat),
    .o_BUSY(busy), .o_STAGE(stage), .o_ELAPSED(elapsed), .o_STAGE_DONE(stage_done),
    .o_DONE_STAGE(done_stage), .o_ALL_DONE(all_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         is_done;
    logic [1:0] stg;
  } ev_t;

  ev_t exp_q [$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  prev_all = 1'b0;

  function automatic logic [NS*CB-1:0] lims(input int l0, input int l1, input int l2, input int l3);
    return {CB'(l3), CB'(l2), CB'(l1), CB'(l0)};
  endfunction

  task automatic pop_cmp(input bit kind, input logic [1:0] stg);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event cycle=%0d kind=%0d stage=%0d, required none", cyc, kind, stg);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != kind || e.at != cyc || (!kind && e.stg != stg)) begin
        n_err++;
        $display("FAIL event got kind=%0d cycle=%0d stage=%0d, required kind=%0d cycle=%0d stage=%0d",
                 kind, cyc, stg, e.is_done, e.at, e.stg);
      end
    end
  endtask

  always @(negedge clk) begin
    if (stage_done) pop_cmp(1'b0, done_stage);
    if (all_done && !prev_all) pop_cmp(1'b1, 2'd0);
    prev_all = all_done;
  end

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int at, input bit kind, input logic [1:0] stg);
    ev_t e;
    e.at = at; e.is_done = kind; e.stg = stg;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int n);
    for (int i = 0; i < n; i++) tick();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic go_abort();
    abort = 1'b1; tick(); abort = 1'b0; tick();
  endtask

  int t0;

  initial begin
    tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_stage", stage, 0);
    check("reset_elapsed", elapsed, 0);
    check("reset_all_done", all_done, 0);
    check("reset_stage_done", stage_done, 0);
    rst_n = 1'b1;
    tick();

    // Three stages {2,0,3}
    stage_en = 4'b0111; lim_flat = lims(2, 0, 3, 7);
    start = 1'b1; t0 = cyc;
    push(t0 + 4, 0, 0); push(t0 + 5, 0, 1); push(t0 + 9, 0, 2); push(t0 + 9, 1, 0);
    tick(); start = 1'b0;
    check("t1_busy_c1", busy, 1);
    check("t1_stage_c1", stage, 0);
    check("t1_elapsed_c1", elapsed, 0);
    while (cyc < t0 + 9) tick();
    check("t1_busy_c9", busy, 0);
    check("t1_stage_hold_c9", stage, 2);
    drain("t1_queue_empty", 3);

    // Restart from DONE with sparse enables
    stage_en = 4'b1010; lim_flat = lims(9, 1, 9, 0);
    start = 1'b1; t0 = cyc;
    push(t0 + 3, 0, 1); push(t0 + 4, 0, 3); push(t0 + 4, 1, 0);
    tick(); start = 1'b0;
    check("t2_all_done_drop", all_done, 0);
    check("t2_stage_c1", stage, 1);
    tick(); tick();
    check("t2_stage_c3", stage, 3);
    drain("t2_queue_empty", 4);
    go_abort();
    check("t2_abort_from_done", all_done, 0);

    // Pause cycles 3..6 on a lim=5 stage
    stage_en = 4'b0001; lim_flat = lims(5, 0, 0, 0);
    start = 1'b1; t0 = cyc;
    push(t0 + 11, 0, 0); push(t0 + 11, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      pause = (i >= 3 && i <= 6);
      if (i >= 4 && i <= 7) check("t3_elapsed_frozen", elapsed, 2);
    end
    pause = 1'b0;
    drain("t3_queue_empty", 2);
    go_abort();

    // Abort at cycle 3 of a lim=5 stage
    start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_elapsed", elapsed, 0);
    check("t4_stage", stage, 0);
    check("t4_all_done", all_done, 0);
    drain("t4_queue_empty", 8);

    // START with ABORT in IDLE stays IDLE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_all_done", all_done, 0);
    drain("t5_queue_empty", 3);

    // Reset mid-run
    stage_en = 4'b0011; lim_flat = lims(3, 3, 0, 0);
    start = 1'b1; t0 = cyc;
    tick(); start = 1'b0; tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t6_busy", busy, 0);
    check("t6_elapsed", elapsed, 0);
    check("t6_stage", stage, 0);
    drain("t6_queue_empty", 8);

    // Mid-run input changes are ignored
    stage_en = 4'b0001; lim_flat = lims(4, 0, 0, 0);
    start = 1'b1; t0 = cyc;
    push(t0 + 6, 0, 0); push(t0 + 6, 1, 0);
    tick(); start = 1'b0; tick();
    lim_flat = '1; stage_en = 4'b1111;
    drain("t7_queue_empty", 7);
    go_abort();

    // No enables: straight to DONE, then restart
    stage_en = 4'b0000;
    start = 1'b1; t0 = cyc;
    push(t0 + 1, 1, 0);
    tick(); start = 1'b0;
    check("t8_all_done", all_done, 1);
    check("t8_busy", busy, 0);
    drain("t8_queue_empty", 3);
    stage_en = 4'b0010; lim_flat = lims(0, 2, 0, 0);
    start = 1'b1; t0 = cyc;
    push(t0 + 4, 0, 1); push(t0 + 4, 1, 0);
    tick(); start = 1'b0;
    check("t8_restart_busy", busy, 1);
    check("t8_restart_all_done", all_done, 0);
    drain("t8_restart_queue_empty", 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d required completion", cyc);
    $fatal(1);
  end
endmodule
